// File: rtl/relu_pool_quant.sv
// relu_pool_quant: optional ReLU, max pooling over POOL samples, arithmetic shift and
// saturation of the conv engine's y stream; registered valid/ready output with frame-end flag.
module relu_pool_quant #(
  parameter int unsigned IN_W     = 21,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned POOL     = 4,
  parameter int unsigned LOGPOOL  = 2,
  parameter int unsigned FRAME    = 225,
  parameter int unsigned LOGFRAME = 8,
  parameter int unsigned SHIFT    = 8,
  parameter bit          RELU_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [OUT_W-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic                    m_last_z
);

  localparam logic signed [IN_W-1:0] SatMax    = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SatMin    = ~SatMax;
  localparam logic [LOGPOOL-1:0]     WinLast   = LOGPOOL'(POOL - 1);
  localparam logic [LOGFRAME-1:0]    FrameLast = LOGFRAME'(FRAME - 1);

  logic [LOGPOOL-1:0]      win_cnt_q, win_cnt_d;
  logic [LOGFRAME-1:0]     frame_cnt_q, frame_cnt_d;
  logic signed [IN_W-1:0]  max_q, max_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  logic                    accept, frame_end, close;
  logic signed [IN_W-1:0]  relu_val, pooled, shifted, sat;

  // Input stalls only while an output is pending and not being taken.
  assign s_ready_y = !reset && (!valid_q || m_ready_z);
  assign accept    = s_valid_y && s_ready_y;
  assign frame_end = (frame_cnt_q == FrameLast);
  assign close     = accept && ((win_cnt_q == WinLast) || frame_end);

  always_comb begin
    relu_val = (RELU_EN && s_data_in_y[IN_W-1]) ? '0 : s_data_in_y;
    if ((win_cnt_q == '0) || (relu_val > max_q)) begin
      pooled = relu_val;
    end else begin
      pooled = max_q;
    end
    shifted = pooled >>> SHIFT;
    if (shifted > SatMax) begin
      sat = SatMax;
    end else if (shifted < SatMin) begin
      sat = SatMin;
    end else begin
      sat = shifted;
    end
  end

  always_comb begin
    win_cnt_d   = win_cnt_q;
    frame_cnt_d = frame_cnt_q;
    max_d       = max_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    if (accept) begin
      max_d       = pooled;
      win_cnt_d   = close ? '0 : win_cnt_q + 1'b1;
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
    end
    // A closing accept reloads the output even while the previous one is handed off.
    if (close) begin
      data_d  = sat[OUT_W-1:0];
      valid_d = 1'b1;
      last_d  = frame_end;
    end else if (valid_q && m_ready_z) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q   <= '0;
      frame_cnt_q <= '0;
      max_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      max_q       <= max_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign m_data_out_z = data_q;
  assign m_valid_z    = valid_q;
  assign m_last_z     = last_q;

endmodule

// File: tb/tb_relu_pool_quant.sv
// Bench for relu_pool_quant: two instances (ReLU on / off) share one input stream and are
// compared against a window-list reference model.
module tb_relu_pool_quant;
  localparam int IN_W = 21, OUT_W = 8, POOL = 4, FRAME = 225, SHIFT = 8;

  logic clk = 1'b0;
  logic reset, s_valid, m_ready;
  logic signed [IN_W-1:0] s_data;
  logic s_ready1, s_ready0, v1, v0, l1, l0;
  logic signed [OUT_W-1:0] z1, z0;

  always #5 clk = ~clk;

  relu_pool_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .POOL(POOL), .LOGPOOL(2), .FRAME(FRAME),
                    .LOGFRAME(8), .SHIFT(SHIFT), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(s_ready1),
    .m_data_out_z(z1), .m_valid_z(v1), .m_ready_z(m_ready), .m_last_z(l1));

  relu_pool_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .POOL(POOL), .LOGPOOL(2), .FRAME(FRAME),
                    .LOGFRAME(8), .SHIFT(SHIFT), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(s_valid), .s_ready_y(s_ready0),
    .m_data_out_z(z0), .m_valid_z(v0), .m_ready_z(m_ready), .m_last_z(l0));

  int errors, checks;
  int tx[$];
  int win1[$], win0[$];
  int fcnt = 0;
  int mv;
  int exp1[$], exp0[$], got1[$], got0[$];
  bit expl[$], gotl1[$], gotl0[$];

  // Floor division by 2^SHIFT, then clamp to the signed output range.
  function automatic int quant(input int m);
    int d, q;
    d = 1 << SHIFT;
    q = (m >= 0) ? m / d : -((-m + d - 1) / d);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic int wmax(input int w[$]);
    int m;
    m = w[0];
    foreach (w[i]) if (w[i] > m) m = w[i];
    return m;
  endfunction

  function automatic int rnd();
    logic signed [IN_W-1:0] t;
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 80000)) - 40000;
    t = IN_W'($urandom);
    return int'(t);
  endfunction

  // Reference model and output capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      win1.delete(); win0.delete(); fcnt = 0;
    end else begin
      if (s_valid && s_ready1) begin
        mv = int'(s_data);
        win1.push_back(mv < 0 ? 0 : mv);
        win0.push_back(mv);
        fcnt++;
        if (win1.size() == POOL || fcnt == FRAME) begin
          exp1.push_back(quant(wmax(win1)));
          exp0.push_back(quant(wmax(win0)));
          expl.push_back(fcnt == FRAME);
          win1.delete(); win0.delete();
          if (fcnt == FRAME) fcnt = 0;
        end
      end
      if (v1 && m_ready) begin got1.push_back(int'(z1)); gotl1.push_back(l1); end
      if (v0 && m_ready) begin got0.push_back(int'(z0)); gotl0.push_back(l0); end
    end
  end

  task automatic clear_q();
    exp1.delete(); exp0.delete(); expl.delete();
    got1.delete(); got0.delete(); gotl1.delete(); gotl0.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
  endtask

  task automatic drain();
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Sends every entry of tx, keeping valid high between samples; returns 1 step after the
  // edge that accepted the last one.
  task automatic send_seq();
    int n;
    foreach (tx[i]) begin
      s_data = tx[i][IN_W-1:0];
      s_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready1 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) begin
        errors++;
        $display("FAIL send_timeout: s_ready_y=0 for 100 cycles, required 1");
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 21'sd100; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready1 !== 1'b0 || s_ready0 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b, required 0", s_ready1, s_ready0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (v1 !== 1'b0 || l1 !== 1'b0 || z1 !== 8'sd0 || v0 !== 1'b0 || z0 !== 8'sd0) begin
      errors++; $display("FAIL reset_out: got v=%b l=%b z=%0d, required 0 0 0", v1, l1, z1);
    end
    reset = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready1 !== 1'b1 || v1 !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b valid=%b, required 1 0", s_ready1, v1);
    end
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_basic();
    clear_q();
    tx = '{256, 1024, -5000, 512};
    send_seq();
    checks++;
    if (v1 !== 1'b1 || z1 !== 8'sd4 || z0 !== 8'sd4 || l1 !== 1'b0) begin
      errors++; $display("FAIL basic_latency: got v=%b z=%0d/%0d l=%b, required 1 4/4 0",
                         v1, z1, z0, l1);
    end
    @(posedge clk); #1;
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle: got m_valid_z=%b, required 0", v1);
    end
    drain();
    checks++;
    if (got1.size() != 1 || exp1.size() != 1 || got1[0] != exp1[0] || got0[0] != exp0[0]) begin
      errors++; $display("FAIL basic_model: got %0d outputs, required 1 matching model", got1.size());
    end
  endtask

  task automatic test_saturation();
    clear_q();
    tx = '{40000, 0, 0, 0, -60000, -60000, -60000, -60000};
    send_seq();
    drain();
    checks++;
    if (got1.size() != 2 || got0.size() != 2 || got1[0] != 127 || got0[0] != 127 ||
        got1[1] != 0 || got0[1] != -128) begin
      errors++; $display("FAIL saturation: got n=%0d z1=%p z0=%p, required {127,0} {127,-128}",
                         got1.size(), got1, got0);
    end
    checks++;
    if (got1 != exp1 || got0 != exp0 || gotl1 != expl) begin
      errors++; $display("FAIL saturation_model: got %p/%p, required %p/%p", got1, got0, exp1, exp0);
    end
  endtask

  task automatic test_relu();
    clear_q();
    tx = '{-300, -10, -2000, -1};
    send_seq();
    drain();
    checks++;
    if (got1.size() != 1 || got0.size() != 1 || got1[0] != 0 || got0[0] != -1) begin
      errors++; $display("FAIL relu: got z1=%p z0=%p, required {0} {-1}", got1, got0);
    end
  endtask

  task automatic test_full_frame();
    apply_reset();
    m_ready = 1'b1;
    tx.delete();
    repeat (FRAME + 4) tx.push_back(512);
    send_seq();
    drain();
    checks++;
    if (got1.size() != 58 || got0.size() != 58) begin
      errors++; $display("FAIL frame_count: got %0d/%0d outputs, required 58", got1.size(), got0.size());
    end else begin
      foreach (got1[i]) begin
        checks++;
        if (got1[i] != 2 || got0[i] != 2 || gotl1[i] != (i == 56) || gotl0[i] != (i == 56)) begin
          errors++; $display("FAIL frame_out[%0d]: got z=%0d/%0d last=%b/%b, required z=2 last=%b",
                             i, got1[i], got0[i], gotl1[i], gotl0[i], i == 56);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int hold, last225;
    apply_reset();
    m_ready = 1'b1;
    tx.delete();
    repeat (220) tx.push_back(rnd());
    send_seq();
    @(posedge clk); #1;
    m_ready = 1'b0;
    tx.delete();
    repeat (4) tx.push_back(rnd());
    send_seq();
    hold = exp1[exp1.size()-1];
    s_data = IN_W'(rnd());
    s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (s_ready1 !== 1'b0 || v1 !== 1'b1 || l1 !== 1'b0 || int'(z1) != hold) begin
        errors++; $display("FAIL bp_hold: got ready=%b v=%b l=%b z=%0d, required 0 1 0 %0d",
                           s_ready1, v1, l1, z1, hold);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    mv = int'(s_data);
    last225 = quant(mv < 0 ? 0 : mv);
    checks++;
    if (v1 !== 1'b1 || l1 !== 1'b1 || int'(z1) != last225) begin
      errors++; $display("FAIL bp_reload: got v=%b l=%b z=%0d, required 1 1 %0d", v1, l1, z1, last225);
    end
    @(posedge clk); #1;
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL bp_done: got m_valid_z=%b, required 0", v1);
    end
    drain();
    checks++;
    if (got1 != exp1 || got0 != exp0 || gotl1 != expl || gotl0 != expl || got1.size() != 57) begin
      errors++; $display("FAIL bp_model: got %0d outputs, required 57 matching model", got1.size());
    end
  endtask

  task automatic test_reset_mid_window();
    tx = '{2000, 3000};
    send_seq();
    apply_reset();
    tx = '{256, 256, 256, 256};
    send_seq();
    drain();
    checks++;
    if (got1.size() != 1 || got0.size() != 1 || got1[0] != 1 || got0[0] != 1 || gotl1[0] != 1'b0) begin
      errors++; $display("FAIL reset_mid: got z1=%p z0=%p, required {1} {1} last 0", got1, got0);
    end
  endtask

  // Completes the frame begun above under random valid/ready; the final output must be last.
  task automatic test_random();
    int idx, cyc, hz;
    bit hold, hl;
    clear_q();
    tx.delete();
    repeat (FRAME - 4) tx.push_back(rnd());
    idx = 0; cyc = 0; hold = 1'b0; hz = 0; hl = 1'b0;
    while (idx < FRAME - 4 && cyc < 5000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = tx[idx][IN_W-1:0];
      @(negedge clk);
      if (hold) begin
        checks++;
        if (v1 !== 1'b1 || int'(z1) != hz || l1 !== hl) begin
          errors++; $display("FAIL rand_hold: got v=%b z=%0d l=%b, required 1 %0d %b", v1, z1, l1, hz, hl);
        end
      end
      hold = v1 && !m_ready; hz = int'(z1); hl = l1;
      if (s_valid && s_ready1) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < FRAME - 4) begin
      errors++; $display("FAIL rand_timeout: sent %0d samples, required %0d", idx, FRAME - 4);
    end
    drain();
    checks++;
    if (got1 != exp1 || got0 != exp0 || gotl1 != expl || gotl0 != expl) begin
      errors++; $display("FAIL rand_model: got %0d/%0d outputs, required %0d matching model",
                         got1.size(), got0.size(), exp1.size());
    end
    checks++;
    if (gotl1.size() != 56 || gotl1[55] != 1'b1) begin
      errors++; $display("FAIL rand_last: got %0d outputs, required 56 ending with last", gotl1.size());
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_full_frame();
    test_backpressure();
    test_reset_mid_window();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/relu_pool_quant.md
Name: relu_pool_quant

Overview:
- Downstream stage of the 8-bit 1-D convolution engine (x 256 samples, f 32 taps, 225 signed 21-bit y results per frame).
- Consumes the y stream over a valid/ready handshake and applies optional ReLU.
- Max-pools each run of POOL consecutive results, then arithmetic-right-shifts and saturates the pooled value to OUT_W signed bits for the next layer.
- Registered output stream with valid/ready and an end-of-frame marker.

Parameters:
IN_W, 21, signed input sample width
OUT_W, 8, signed output sample width
POOL, 4, pooling window length in samples (>=1)
LOGPOOL, 2, width of window counter (ceil log2 POOL, min 1)
FRAME, 225, input samples per frame
LOGFRAME, 8, width of frame sample counter
SHIFT, 8, arithmetic right-shift applied to pooled value
RELU_EN, 1, 1 = clamp negative inputs to 0 before pooling

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
s_data_in_y  input  IN_W  signed conv result
s_valid_y  input  1  input sample valid
s_ready_y  output  1  block accepts input this cycle
m_data_out_z  output  OUT_W  signed pooled/quantized result
m_valid_z  output  1  output valid
m_ready_z  input  1  downstream accepts output
m_last_z  output  1  qualifies m_valid_z: last output of frame

Behaviour:
- Reset values: m_data_out_z=0, m_valid_z=0, m_last_z=0, window count=0, frame count=0, max register=0. s_ready_y=0 while reset is high.
- Accept: occurs when s_valid_y && s_ready_y.
- s_ready_y: combinational, = !reset && (!m_valid_z || m_ready_z). Input is stalled only while an output is pending and not being taken.
- ReLU: r = (RELU_EN && v<0) ? 0 : v. Comparisons are signed, IN_W bits.
- On accept with window count==0: max_reg <= r. Otherwise max_reg <= max(max_reg, r).
- Window close: on an accept where window count==POOL-1 OR frame count==FRAME-1.
  - pooled = max(max_reg, r), or r if window count==0.
  - q = pooled >>> SHIFT (arithmetic shift).
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - m_data_out_z <= q, m_valid_z <= 1, m_last_z <= (frame count==FRAME-1).
  - Window count <= 0.
- Non-closing accept: window count +1.
- Frame count: +1 per accept; wraps to 0 on the accept at FRAME-1. Any partial final window is flushed at frame end (FRAME=225, POOL=4: 56 full windows + 1 window of 1 sample = 57 outputs).
- Latency: 1 cycle from the closing accept to m_valid_z=1.
- Output hold: while m_valid_z && !m_ready_z, m_data_out_z and m_last_z are stable.
- Handshake completion: when m_valid_z && m_ready_z and there is no closing accept in the same cycle, m_valid_z <= 0 and m_last_z <= 0. A simultaneous closing accept reloads the register, giving full throughput even with POOL=1.
- m_valid_z never drops without a handshake, except on reset.
- Reset mid-window or mid-frame: partial max and both counters are discarded; a pending output is dropped. The next accepted sample starts a new window and a new frame.
- No input is accepted in the same cycle reset is high.

Test Plan:
- Basic pool: POOL=4, SHIFT=8, RELU_EN=1; inputs 256, 1024, -5000, 512; m_ready_z=1 -> one output z=4, m_valid_z high exactly 1 cycle after the 4th accept, m_last_z=0.
- Saturation: inputs 40000, 0, 0, 0 -> z=127. With RELU_EN=0, inputs -60000 x4 -> -60000>>>8 = -235 -> z=-128.
- ReLU on/off: inputs -300, -10, -2000, -1 -> z=0 with RELU_EN=1; z=-1 with RELU_EN=0.
- Full frame: 225 samples, all equal 512, continuous valid -> exactly 57 outputs, all z=2. m_last_z=1 only on the 57th, which is produced from sample 225 alone. The next frame's first window starts fresh.
- Backpressure: hold m_ready_z=0 for 10 cycles after a window closes -> s_ready_y=0 for those cycles, z value stable, no input lost. On release, the output transfers, and a window closing in the same cycle appears the next cycle.
- Reset mid-window: accept 2000 and 3000, assert reset 1 cycle, then feed 256 x4 -> single output z=1. No trace of 3000, frame count restarted.
